// File: rtl/mv_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock, valid/ready on both sides.
// Optional macro MV_BIN2BCD_BLANK_EN: leading zero digits are output as 4'hF (display blank).
module mv_bin2bcd #(
  parameter int IN_W   = 12,
  parameter int DIGITS = 4,
  parameter int CH_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_W-1:0]       in,
  input  logic [CH_W-1:0]       in_ch,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [CH_W-1:0]       out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int BCD_W   = 4 * DIGITS;
  localparam int CNT_W   = $clog2(IN_W + 1);
  localparam int BCD_MAX = (10 ** DIGITS) - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]  scr_q, scr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;

  logic [BCD_W-1:0]  scr_adj;
  logic [BCD_W-1:0]  scr_shift;
  logic [BCD_W-1:0]  all_nines;
  logic [BCD_W-1:0]  scr_final;
  logic [BCD_W-1:0]  load_val;

  // Add-3 correction per digit; a digit <= 9 plus 3 never exceeds 4 bits.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign scr_adj[4*gi +: 4]   = (scr_q[4*gi +: 4] >= 4'd5) ? scr_q[4*gi +: 4] + 4'd3
                                                               : scr_q[4*gi +: 4];
      assign all_nines[4*gi +: 4] = 4'h9;
    end
  endgenerate

  // The bit leaving the top of the scratch register is dropped (only reachable when saturated).
  assign scr_shift = BCD_W'({scr_adj, bin_q[IN_W-1]});

`ifdef MV_BIN2BCD_BLANK_EN
  always_comb begin
    logic lead;
    scr_final = scr_shift;
    lead      = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (scr_shift[4*i +: 4] == 4'h0)) begin
        scr_final[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  assign scr_final = scr_shift;
`endif

  assign load_val = sat_q ? all_nines : scr_final;

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    scr_d    = scr_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    ch_d     = ch_q;
    bcd_d    = bcd_q;
    out_ch_d = out_ch_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = in;
          ch_d    = in_ch;
          sat_d   = (32'(in) > 32'(BCD_MAX));
          scr_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = scr_shift;
        bin_d = {bin_q[IN_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          bcd_d    = load_val;
          out_ch_d = ch_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      scr_q    <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      ch_q     <= '0;
      bcd_q    <= '0;
      out_ch_q <= '0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      scr_q    <= scr_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      ch_q     <= ch_d;
      bcd_q    <= bcd_d;
      out_ch_q <= out_ch_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bcd       = bcd_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mv_bin2bcd.sv
// Directed self-checking bench for mv_bin2bcd: default build plus a 14-bit saturation instance.
module tb_mv_bin2bcd;

`ifdef MV_BIN2BCD_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] in_v;
  logic [3:0]  in_ch;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bcd;
  logic [3:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  logic [13:0] in14;
  logic [3:0]  in_ch14;
  logic        in_valid14;
  logic        in_ready14;
  logic [15:0] bcd14;
  logic [3:0]  out_ch14;
  logic        out_valid14;
  logic        out_ready14;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mv_bin2bcd dut (
    .clk(clk), .rst(rst), .in(in_v), .in_ch(in_ch), .in_valid(in_valid),
    .in_ready(in_ready), .bcd(bcd), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mv_bin2bcd #(.IN_W(14), .DIGITS(4), .CH_W(4)) dut14 (
    .clk(clk), .rst(rst), .in(in14), .in_ch(in_ch14), .in_valid(in_valid14),
    .in_ready(in_ready14), .bcd(bcd14), .out_ch(out_ch14), .out_valid(out_valid14),
    .out_ready(out_ready14)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a value, wait for it to be accepted, then count edges until out_valid (-1 on timeout).
  task automatic convert(input logic [11:0] v, input logic [3:0] ch, output int lat);
    int k;
    in_v = v; in_ch = ch; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin tick(); k++; end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    if (lat >= 100) lat = -1;
    $display("xfer in=%0d ch=%0d -> bcd=%h out_ch=%0d latency=%0d", v, ch, bcd, out_ch, lat);
  endtask

  task automatic convert14(input logic [13:0] v, output int lat);
    int k;
    in14 = v; in_ch14 = 4'd9; in_valid14 = 1'b1;
    k = 0;
    while (!in_ready14 && k < 100) begin tick(); k++; end
    tick();
    in_valid14 = 1'b0;
    lat = 0;
    while (!out_valid14 && lat < 100) begin tick(); lat++; end
    if (lat >= 100) lat = -1;
    $display("xfer14 in=%0d -> bcd=%h latency=%0d", v, bcd14, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd !== 16'h0 || out_ch !== 4'd0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b bcd=%h out_ch=%0d required 1 0 0000 0",
               in_ready, out_valid, bcd, out_ch);
    end
  endtask

  task automatic test_zero();
    int lat;
    logic [15:0] exp_bcd;
    exp_bcd = BLANK ? 16'hFFF0 : 16'h0000;
    convert(12'd0, 4'd0, lat);
    checks++;
    if (lat !== 12) begin errors++; $display("FAIL zero_latency: got %0d required 12", lat); end
    checks++;
    if (bcd !== exp_bcd || out_ch !== 4'd0) begin
      errors++; $display("FAIL zero_value: bcd=%h ch=%0d required %h 0", bcd, out_ch, exp_bcd);
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL zero_ready_done: in_ready=%b required 0", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || bcd !== exp_bcd) begin
      errors++;
      $display("FAIL zero_release: out_valid=%b in_ready=%b bcd=%h required 0 1 %h",
               out_valid, in_ready, bcd, exp_bcd);
    end
  endtask

  task automatic test_values();
    int lat;
    logic [11:0] vin [4]  = '{12'd3299, 12'd4095, 12'd42, 12'd1005};
    logic [3:0]  vch [4]  = '{4'd12, 4'd5, 4'd7, 4'd1};
    logic [15:0] vexp [4] = '{16'h3299, 16'h4095, 16'h0042, 16'h1005};
    logic [15:0] e;
    for (int i = 0; i < 4; i++) begin
      e = vexp[i];
      if (BLANK && i == 2) e = 16'hFF42;
      convert(vin[i], vch[i], lat);
      checks++;
      if (lat !== 12 || bcd !== e || out_ch !== vch[i]) begin
        errors++;
        $display("FAIL value_%0d: lat=%0d bcd=%h ch=%0d required 12 %h %0d",
                 vin[i], lat, bcd, out_ch, e, vch[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad;
    logic [15:0] e777;
    e777 = BLANK ? 16'hF777 : 16'h0777;
    out_ready = 1'b0;
    convert(12'd1234, 4'd3, lat);
    in_v = 12'd777; in_ch = 4'd6; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b1 || bcd !== 16'h1234 || out_ch !== 4'd3 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || lat !== 12) begin
      errors++;
      $display("FAIL backpressure_hold: bad_cycles=%0d lat=%0d bcd=%h ch=%0d in_ready=%b required 0 12 1234 3 0",
               bad, lat, bcd, out_ch, in_ready);
    end
    out_ready = 1'b1;
    convert(12'd777, 4'd6, lat);
    checks++;
    if (lat !== 12 || bcd !== e777 || out_ch !== 4'd6) begin
      errors++;
      $display("FAIL backpressure_next: lat=%0d bcd=%h ch=%0d required 12 %h 6", lat, bcd, out_ch, e777);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    in_v = 12'd2048; in_ch = 4'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd !== 16'h0 || out_ch !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b bcd=%h ch=%0d required 1 0 0000 0",
               in_ready, out_valid, bcd, out_ch);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_mid_no_valid: pulses=%0d required 0", seen); end
    convert(12'd2048, 4'd2, lat);
    checks++;
    if (lat !== 12 || bcd !== 16'h2048 || out_ch !== 4'd2) begin
      errors++;
      $display("FAIL reset_mid_retry: lat=%0d bcd=%h ch=%0d required 12 2048 2", lat, bcd, out_ch);
    end
    tick();
  endtask

  task automatic test_saturate();
    int lat;
    logic [13:0] vin [4]  = '{14'd16383, 14'd9999, 14'd10000, 14'd1234};
    logic [15:0] vexp [4] = '{16'h9999, 16'h9999, 16'h9999, 16'h1234};
    for (int i = 0; i < 4; i++) begin
      convert14(vin[i], lat);
      checks++;
      if (lat !== 14 || bcd14 !== vexp[i] || out_ch14 !== 4'd9) begin
        errors++;
        $display("FAIL saturate_%0d: lat=%0d bcd=%h ch=%0d required 14 %h 9",
                 vin[i], lat, bcd14, out_ch14, vexp[i]);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; in_v = '0; in_ch = '0; in_valid = 1'b0; out_ready = 1'b1;
    in14 = '0; in_ch14 = '0; in_valid14 = 1'b0; out_ready14 = 1'b1;
    test_reset();
    test_zero();
    test_values();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
